// File: rtl/conv_10_12_sdiv_seq_pkg.sv
// rtl/conv_10_12_sdiv_seq_pkg.sv - shared widths, step count, FSM states and saturation limits
// Purpose : common constants for the sequential signed divider and its step cell.
// Contents: DIN0_W/DIN1_W/DOUT_W operand widths, STEPS iteration count,
//           state_t FSM encoding, SAT_POS/SAT_NEG quotient saturation limits.
package conv_10_12_sdiv_seq_pkg;

   localparam int DIN0_W  = 24;
   localparam int DIN1_W  = 8;
   localparam int DOUT_W  = 16;
   localparam int STEPS   = 24;

   localparam int SAT_POS = 32767;
   localparam int SAT_NEG = -32768;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } state_t;

endpackage

// File: rtl/conv_10_12_sdiv_step.sv
// rtl/conv_10_12_sdiv_step.sv - one combinational restoring shift-subtract step
// Purpose : shifts the next dividend bit into the partial remainder and
//           subtracts the divisor magnitude when it fits.
// Ports   : i_rem  partial remainder in (unsigned, < divisor)
//           i_bit  next dividend magnitude bit (MSB first)
//           i_div  divisor magnitude (unsigned)
//           o_qbit quotient bit produced by this step
//           o_rem  partial remainder out
module conv_10_12_sdiv_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_rem,
   input  logic         i_bit,
   input  logic [W-1:0] i_div,
   output logic         o_qbit,
   output logic [W-1:0] o_rem
);

   logic [W:0] w_sh;

   assign w_sh   = {i_rem, i_bit};
   assign o_qbit = (w_sh >= {1'b0, i_div});
   // When the divisor fits, the true difference is below the divisor and
   // therefore fits in W bits, so a W-bit subtraction is exact.
   assign o_rem  = o_qbit ? (w_sh[W-1:0] - i_div) : w_sh[W-1:0];

endmodule

// File: rtl/conv_10_12_sdiv_seq.sv
// rtl/conv_10_12_sdiv_seq.sv - sequential signed divider, 24-bit / 8-bit -> 16-bit quotient
// Purpose : restoring divider on operand magnitudes; signs applied afterwards,
//           quotient saturated to 16 bits, divide-by-zero flagged.
//           Latency from accepting edge to out_valid is a fixed 26 edges.
// Ports   : ap_clk, ap_rst_n (sync, active-low)
//           in_valid/in_ready, din0 (signed dividend), din1 (signed divisor)
//           out_valid/out_ready, dout (signed quotient), rem (signed remainder),
//           ovf (quotient saturated), dz (divide by zero)
// Macro   : CONV_10_12_SDIV_REM_EN - when defined, rem carries the signed
//           remainder; otherwise rem is tied to 0.
module conv_10_12_sdiv_seq
   import conv_10_12_sdiv_seq_pkg::*;
#(
   parameter int din0_WIDTH = DIN0_W,
   parameter int din1_WIDTH = DIN1_W,
   parameter int dout_WIDTH = DOUT_W
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  ovf,
   output logic                  dz
);

   localparam int                     CNT_W   = $clog2(STEPS + 1);
   localparam logic [CNT_W-1:0]       LAST    = CNT_W'(STEPS);
   localparam logic [dout_WIDTH-1:0]  Q_MAX   = dout_WIDTH'(SAT_POS);
   localparam logic [dout_WIDTH-1:0]  Q_MIN   = dout_WIDTH'(SAT_NEG);
   localparam logic [din0_WIDTH-1:0]  MAG_POS = din0_WIDTH'(SAT_POS);
   localparam logic [din0_WIDTH-1:0]  MAG_NEG = din0_WIDTH'(-SAT_NEG);

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [din0_WIDTH-1:0]   r_a;      // dividend magnitude, becomes quotient magnitude
   logic [din1_WIDTH-1:0]   r_b;      // divisor magnitude
   logic [din1_WIDTH-1:0]   r_pr;     // partial remainder magnitude
   logic                    r_s0;
   logic                    r_s1;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic [dout_WIDTH-1:0]   r_dout;
   logic [din1_WIDTH-1:0]   r_rem;
   logic                    r_ovf;
   logic                    r_dz;

   logic [din0_WIDTH-1:0]   w_mag0;
   logic [din1_WIDTH-1:0]   w_mag1;
   logic                    w_qbit;
   logic [din1_WIDTH-1:0]   w_pr;
   logic                    w_dz;
   logic                    w_qneg;
   logic [dout_WIDTH-1:0]   w_dout;
   logic [din1_WIDTH-1:0]   w_rem;
   logic                    w_ovf;

   // Two's-complement magnitude as unsigned: the most negative value maps to
   // 2^(N-1), which still fits, so no wrap on -8388608 or -128.
   assign w_mag0 = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;
   assign w_mag1 = din1[din1_WIDTH-1] ? (~din1 + 1'b1) : din1;

   conv_10_12_sdiv_step #(.W(din1_WIDTH)) u_step (
      .i_rem  (r_pr),
      .i_bit  (r_a[din0_WIDTH-1]),
      .i_div  (r_b),
      .o_qbit (w_qbit),
      .o_rem  (w_pr)
   );

   assign w_dz   = (r_b == '0);
   assign w_qneg = r_s0 ^ r_s1;

   always_comb begin
      w_dout = '0;
      w_rem  = '0;
      w_ovf  = 1'b0;
      if (w_dz) begin
         w_dout = r_s0 ? Q_MIN : Q_MAX;
      end else if (!w_qneg) begin
         if (r_a > MAG_POS) begin
            w_dout = Q_MAX;
            w_ovf  = 1'b1;
         end else begin
            w_dout = dout_WIDTH'(r_a);
         end
      end else begin
         // Negative side reaches one further: magnitude 32768 is exact.
         if (r_a > MAG_NEG) begin
            w_dout = Q_MIN;
            w_ovf  = 1'b1;
         end else begin
            w_dout = dout_WIDTH'(~r_a + 1'b1);
         end
      end
`ifdef CONV_10_12_SDIV_REM_EN
      // Remainder follows the dividend's sign.
      if (!w_dz) begin
         w_rem = r_s0 ? (~r_pr + 1'b1) : r_pr;
      end
`endif
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_pr        <= '0;
         r_s0        <= 1'b0;
         r_s1        <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_dout      <= '0;
         r_rem       <= '0;
         r_ovf       <= 1'b0;
         r_dz        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= w_mag0;
                  r_b        <= w_mag1;
                  r_s0       <= din0[din0_WIDTH-1];
                  r_s1       <= din1[din1_WIDTH-1];
                  r_pr       <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_CALC;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            ST_CALC: begin
               // The cycle after the last step only hands over to FIX; this
               // keeps the accept-to-valid latency at 26 edges.
               if (r_cnt == LAST) begin
                  r_state <= ST_FIX;
               end else begin
                  r_a   <= {r_a[din0_WIDTH-2:0], w_qbit};
                  r_pr  <= w_pr;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_FIX: begin
               r_dout      <= w_dout;
               r_rem       <= w_rem;
               r_ovf       <= w_ovf;
               r_dz        <= w_dz;
               r_out_valid <= 1'b1;
               r_state     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_ovf       <= 1'b0;
                  r_dz        <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign dout      = r_dout;
   assign rem       = r_rem;
   assign ovf       = r_ovf;
   assign dz        = r_dz;

endmodule
